// File: rtl/nes_bus_pkg.sv
// Address map, DMA state encoding and read-source decode shared by the CPU bus responder.
package nes_bus_pkg;

   localparam logic [15:0] RAM_END  = 16'h1FFF;
   localparam logic [15:0] PPU_BASE = 16'h2000;
   localparam logic [15:0] PPU_END  = 16'h3FFF;
   localparam logic [15:0] DMA_REG  = 16'h4014;
   localparam logic [15:0] JOY1_REG = 16'h4016;
   localparam logic [15:0] JOY2_REG = 16'h4017;
   localparam logic [15:0] PRG_BASE = 16'h8000;

   localparam int JOY_A      = 0;
   localparam int JOY_B      = 1;
   localparam int JOY_SELECT = 2;
   localparam int JOY_START  = 3;
   localparam int JOY_UP     = 4;
   localparam int JOY_DOWN   = 5;
   localparam int JOY_LEFT   = 6;
   localparam int JOY_RIGHT  = 7;

   typedef enum logic [1:0] {DMA_IDLE, DMA_ALIGN, DMA_RD, DMA_WR} dma_state_t;

   typedef enum logic [2:0] {SEL_OPEN, SEL_RAM, SEL_PPU, SEL_JOY1, SEL_JOY2, SEL_PRG} sel_t;

   function automatic sel_t decode(input logic [15:0] a);
      sel_t s;
      s = SEL_OPEN;
      if (a <= RAM_END)                      s = SEL_RAM;
      else if (a >= PPU_BASE && a <= PPU_END) s = SEL_PPU;
      else if (a == JOY1_REG)                s = SEL_JOY1;
      else if (a == JOY2_REG)                s = SEL_JOY2;
      else if (a >= PRG_BASE)                s = SEL_PRG;
      return s;
   endfunction

endpackage

// File: rtl/nes_joypad.sv
// Controller shift register: parallel load while strobed, shifts right filling 1s on reads.
module nes_joypad (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_strobe,
   input  logic       i_shift,
   input  logic [7:0] i_buttons,
   output logic       o_data
);
   logic [7:0] r_sr;

   // Load takes priority over a coincident shift.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)         r_sr <= '0;
      else if (i_strobe) r_sr <= i_buttons;
      else if (i_shift)  r_sr <= {1'b1, r_sr[7:1]};
   end

   assign o_data = r_sr[0];
endmodule

// File: rtl/nes_bus.sv
// CPU bus responder: address decode, read mux with open-bus latch, joypads and $4014 OAM DMA.
module nes_bus
   import nes_bus_pkg::*;
#(
   parameter int          DMA_PAGE_BITS = 8,
   parameter logic [7:0]  OPEN_BUS_INIT = 8'hFF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_cpu_addr,
   input  logic [15:0] i_cpu_eawr,
   input  logic [7:0]  i_cpu_dout,
   input  logic        i_cpu_wreq,
   input  logic        i_cpu_rd,
   output logic [7:0]  o_cpu_din,
   output logic        o_cpu_ce,
   output logic [10:0] o_ram_addr,
   input  logic [7:0]  i_ram_din,
   output logic [7:0]  o_ram_dout,
   output logic        o_ram_we,
   output logic [14:0] o_prg_addr,
   input  logic [7:0]  i_prg_din,
   output logic [2:0]  o_ppu_addr,
   input  logic [7:0]  i_ppu_din,
   output logic [7:0]  o_ppu_dout,
   output logic        o_ppu_we,
   output logic        o_ppu_re,
   input  logic [7:0]  i_joy1,
   input  logic [7:0]  i_joy2
);
   dma_state_t               r_state, w_state_nxt;
   logic [DMA_PAGE_BITS-1:0] r_page;
   logic [7:0]               r_idx, r_byte, r_open;
   logic                     r_strobe, r_rd_q;
   logic                     w_idle, w_dma_rd, w_dma_wr;
   logic                     w_wr, w_rd_rise, w_dma_start, w_joy1_bit, w_joy2_bit;
   logic [15:0]              w_dma_addr;
   sel_t                     w_rsel, w_wsel, w_dsel;

   assign w_rsel      = decode(i_cpu_addr);
   assign w_wsel      = decode(i_cpu_eawr);
   assign w_dma_addr  = {r_page, r_idx};
   assign w_dsel      = decode(w_dma_addr);
   // CPU strobes are ignored while the DMA owns the bus.
   assign w_wr        = i_cpu_wreq & w_idle;
   assign w_rd_rise   = i_cpu_rd & ~r_rd_q & w_idle;
   assign w_dma_start = w_wr & (i_cpu_eawr == DMA_REG);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= DMA_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         DMA_IDLE:  if (w_dma_start) w_state_nxt = DMA_ALIGN;
         DMA_ALIGN: w_state_nxt = DMA_RD;
         DMA_RD:    w_state_nxt = DMA_WR;
         DMA_WR:    w_state_nxt = (r_idx == 8'hFF) ? DMA_IDLE : DMA_RD;
         default:   w_state_nxt = DMA_IDLE;
      endcase
   end

   always_comb begin
      w_idle   = 1'b0;
      w_dma_rd = 1'b0;
      w_dma_wr = 1'b0;
      case (r_state)
         DMA_IDLE: w_idle   = 1'b1;
         DMA_RD:   w_dma_rd = 1'b1;
         DMA_WR:   w_dma_wr = 1'b1;
         default:  ;
      endcase
   end

   // Open-bus latch freezes during DMA so the stall cannot disturb it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_page   <= '0;
         r_idx    <= '0;
         r_byte   <= '0;
         r_open   <= OPEN_BUS_INIT;
         r_strobe <= 1'b0;
         r_rd_q   <= 1'b0;
      end else begin
         r_rd_q <= i_cpu_rd;
         if (w_idle) r_open <= o_cpu_din;
         if (w_dma_start) begin
            r_page <= i_cpu_dout[DMA_PAGE_BITS-1:0];
            r_idx  <= '0;
         end
         if (w_dma_rd) begin
            case (w_dsel)
               SEL_RAM: r_byte <= i_ram_din;
               SEL_PRG: r_byte <= i_prg_din;
               default: r_byte <= r_open;
            endcase
         end
         if (w_dma_wr) r_idx <= r_idx + 8'd1;
         if (w_wr && w_wsel == SEL_JOY1) r_strobe <= i_cpu_dout[0];
      end
   end

   nes_joypad u_joy1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_strobe(r_strobe),
      .i_shift(w_rd_rise & (w_rsel == SEL_JOY1)), .i_buttons(i_joy1), .o_data(w_joy1_bit)
   );
   nes_joypad u_joy2 (
      .i_clk(i_clk), .i_rst(i_rst), .i_strobe(r_strobe),
      .i_shift(w_rd_rise & (w_rsel == SEL_JOY2)), .i_buttons(i_joy2), .o_data(w_joy2_bit)
   );

   always_comb begin
      o_ram_addr = i_cpu_addr[10:0];
      o_prg_addr = i_cpu_addr[14:0];
      o_ppu_addr = i_cpu_addr[2:0];
      o_ppu_dout = i_cpu_dout;
      if (!w_idle) begin
         o_ram_addr = w_dma_addr[10:0];
         o_prg_addr = w_dma_addr[14:0];
      end else if (w_wr && w_wsel == SEL_RAM) begin
         o_ram_addr = i_cpu_eawr[10:0];
      end
      if (w_dma_wr) begin
         o_ppu_addr = 3'd4;
         o_ppu_dout = r_byte;
      end else if (w_wr && w_wsel == SEL_PPU) begin
         o_ppu_addr = i_cpu_eawr[2:0];
      end
   end

   always_comb begin
      case (w_rsel)
         SEL_RAM:  o_cpu_din = i_ram_din;
         SEL_PRG:  o_cpu_din = i_prg_din;
         SEL_PPU:  o_cpu_din = i_ppu_din;
         SEL_JOY1: o_cpu_din = {3'b010, 4'b0000, w_joy1_bit};
         SEL_JOY2: o_cpu_din = {3'b010, 4'b0000, w_joy2_bit};
         default:  o_cpu_din = r_open;
      endcase
   end

   assign o_ram_dout = i_cpu_dout;
   assign o_ram_we   = w_wr & (w_wsel == SEL_RAM);
   assign o_ppu_we   = w_dma_wr | (w_wr & (w_wsel == SEL_PPU));
   assign o_ppu_re   = w_rd_rise & (w_rsel == SEL_PPU);
   assign o_cpu_ce   = w_idle;
endmodule

// File: tb/tb_nes_bus.sv
// Directed plus randomized checks of nes_bus against emulated memories and a bench-side model.
module tb_nes_bus;
   logic        clk, rst;
   logic [15:0] cpu_addr, cpu_eawr;
   logic [7:0]  cpu_dout, cpu_din;
   logic        cpu_wreq, cpu_rd, cpu_ce;
   logic [10:0] ram_addr;
   logic [7:0]  ram_din, ram_dout;
   logic        ram_we;
   logic [14:0] prg_addr;
   logic [7:0]  prg_din;
   logic [2:0]  ppu_addr;
   logic [7:0]  ppu_din, ppu_dout;
   logic        ppu_we, ppu_re;
   logic [7:0]  joy1, joy2;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [2048];
   logic [7:0]  model_ram [2048];
   logic [10:0] ppu_log [$];

   nes_bus dut (
      .i_clk(clk), .i_rst(rst), .i_cpu_addr(cpu_addr), .i_cpu_eawr(cpu_eawr),
      .i_cpu_dout(cpu_dout), .i_cpu_wreq(cpu_wreq), .i_cpu_rd(cpu_rd),
      .o_cpu_din(cpu_din), .o_cpu_ce(cpu_ce),
      .o_ram_addr(ram_addr), .i_ram_din(ram_din), .o_ram_dout(ram_dout), .o_ram_we(ram_we),
      .o_prg_addr(prg_addr), .i_prg_din(prg_din),
      .o_ppu_addr(ppu_addr), .i_ppu_din(ppu_din), .o_ppu_dout(ppu_dout),
      .o_ppu_we(ppu_we), .o_ppu_re(ppu_re), .i_joy1(joy1), .i_joy2(joy2)
   );

   function automatic logic [7:0] prgf(input logic [14:0] a);
      return a[7:0] ^ {1'b0, a[14:8]};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // External async-read memories and a log of every PPU register write.
   assign ram_din = mem[ram_addr];
   assign prg_din = prgf(prg_addr);
   assign ppu_din = 8'hC0 | {5'd0, ppu_addr};
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_dout;
      if (ppu_we) ppu_log.push_back({ppu_addr, ppu_dout});
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      cpu_wreq = 1'b0; cpu_rd = 1'b0; cpu_addr = 16'h5000; cpu_eawr = 16'h5000; cpu_dout = 8'h00;
   endtask

   // Start a $4014 DMA from page pg; count stalled cycles, illegal strobes, optional reset abort.
   task automatic run_dma(input logic [7:0] pg, input int abort_at, output int cnt, output int ill);
      cnt = 0; ill = 0;
      cpu_wreq = 1'b1; cpu_eawr = 16'h4014; cpu_dout = pg; cpu_addr = 16'h5000; cpu_rd = 1'b0;
      @(negedge clk);
      chk("dma_ce_write_cycle", {15'd0, cpu_ce}, 16'd1);
      nxt();
      for (int c = 0; c < 700; c++) begin
         cpu_wreq = (cnt < 500); cpu_eawr = 16'h0000; cpu_dout = 8'hFF;
         cpu_addr = 16'h2002; cpu_rd = ~cpu_rd;
         @(negedge clk);
         if (cpu_ce) break;
         cnt++;
         if (ram_we || ppu_re) ill++;
         if (cnt == abort_at) begin
            #1 rst = 1'b1;
            #1 chk("abort_ce", {15'd0, cpu_ce}, 16'd1);
            @(posedge clk);
            #1 rst = 1'b0;
            break;
         end
         nxt();
      end
      idle_bus();
      nxt();
   endtask

   initial begin
      int cnt, ill, bad;
      logic [7:0] jm, jexp, last_exp, exp, d;
      logic [15:0] a;

      for (int i = 0; i < 2048; i++) begin
         mem[i] = 8'h00;
         model_ram[i] = 8'h00;
      end
      joy1 = 8'h00; joy2 = 8'h00;
      rst = 1'b1;
      idle_bus();

      // Reset state
      @(negedge clk);
      chk("rst_ce", {15'd0, cpu_ce}, 16'd1);
      chk("rst_ram_we", {15'd0, ram_we}, 16'd0);
      chk("rst_ppu_we", {15'd0, ppu_we}, 16'd0);
      chk("rst_open_bus", {8'd0, cpu_din}, 16'h00FF);
      nxt();
      rst = 1'b0;
      cpu_addr = 16'h8123;
      @(negedge clk);
      chk("prg_read", {8'd0, cpu_din}, {8'd0, prgf(15'h0123)});
      nxt();
      cpu_addr = 16'h5000;
      @(negedge clk);
      chk("open_bus_follow", {8'd0, cpu_din}, {8'd0, prgf(15'h0123)});
      #1 rst = 1'b1;
      #1 chk("rst_idle_open_bus", {8'd0, cpu_din}, 16'h00FF);
      chk("rst_idle_ce", {15'd0, cpu_ce}, 16'd1);
      nxt();
      rst = 1'b0;

      // RAM write with mirroring, then read back through another mirror
      cpu_wreq = 1'b1; cpu_eawr = 16'h0801; cpu_dout = 8'h5A;
      @(negedge clk);
      chk("ram_wr_addr", {5'd0, ram_addr}, 16'h0001);
      chk("ram_wr_we", {15'd0, ram_we}, 16'd1);
      model_ram[1] = 8'h5A;
      nxt();
      idle_bus();
      cpu_addr = 16'h1801;
      @(negedge clk);
      chk("ram_we_pulse", {15'd0, ram_we}, 16'd0);
      chk("ram_rd_addr", {5'd0, ram_addr}, 16'h0001);
      chk("ram_rd_data", {8'd0, cpu_din}, {8'd0, model_ram[1]});
      nxt();

      // PPU register write and read side-effect pulse
      cpu_wreq = 1'b1; cpu_eawr = 16'h3FFF; cpu_dout = 8'h33;
      @(negedge clk);
      chk("ppu_wr_addr", {13'd0, ppu_addr}, 16'd7);
      chk("ppu_wr_data", {8'd0, ppu_dout}, 16'h0033);
      chk("ppu_wr_we", {15'd0, ppu_we}, 16'd1);
      nxt();
      idle_bus();
      cpu_addr = 16'h2002;
      @(negedge clk);
      chk("ppu_we_pulse", {15'd0, ppu_we}, 16'd0);
      chk("ppu_re_fetch", {15'd0, ppu_re}, 16'd0);
      nxt();
      cpu_rd = 1'b1;
      @(negedge clk);
      chk("ppu_re_rise", {15'd0, ppu_re}, 16'd1);
      chk("ppu_rd_data", {8'd0, cpu_din}, 16'h00C2);
      nxt();
      @(negedge clk);
      chk("ppu_re_held", {15'd0, ppu_re}, 16'd0);
      nxt();
      idle_bus();
      nxt();

      // OAM DMA from page $02
      for (int i = 0; i < 256; i++) begin
         mem[11'h200 + 11'(i)] = 8'(i);
         model_ram[11'h200 + 11'(i)] = 8'(i);
      end
      ppu_log.delete();
      run_dma(8'h02, 0, cnt, ill);
      chk("dma_stall_cycles", 16'(cnt), 16'd513);
      chk("dma_ignored_strobes", 16'(ill), 16'd0);
      chk("dma_ppu_writes", 16'(ppu_log.size()), 16'd256);
      bad = 0;
      foreach (ppu_log[i]) if (ppu_log[i] !== {3'd4, 8'(i)}) bad++;
      chk("dma_data", 16'(bad), 16'd0);

      // Joypad 1 serial read
      joy1 = 8'h81;
      cpu_wreq = 1'b1; cpu_eawr = 16'h4016; cpu_dout = 8'h01;
      nxt();
      cpu_dout = 8'h00;
      nxt();
      idle_bus();
      jm = 8'h81;
      for (int k = 0; k < 9; k++) begin
         jexp = 8'h40 | {7'd0, jm[0]};
         jm = {1'b1, jm[7:1]};
         cpu_addr = 16'h4016; cpu_rd = 1'b1;
         @(negedge clk);
         chk($sformatf("joy1_read%0d", k), {8'd0, cpu_din}, {8'd0, jexp});
         nxt();
         cpu_rd = 1'b0;
         nxt();
      end

      // Joypad 2 with random buttons
      joy2 = 8'($urandom);
      cpu_wreq = 1'b1; cpu_eawr = 16'h4016; cpu_dout = 8'h01;
      nxt();
      cpu_dout = 8'h00;
      nxt();
      idle_bus();
      jm = joy2;
      for (int k = 0; k < 9; k++) begin
         jexp = 8'h40 | {7'd0, jm[0]};
         jm = {1'b1, jm[7:1]};
         cpu_addr = 16'h4017; cpu_rd = 1'b1;
         @(negedge clk);
         chk($sformatf("joy2_read%0d", k), {8'd0, cpu_din}, {8'd0, jexp});
         nxt();
         cpu_rd = 1'b0;
         nxt();
      end

      // Reset 100 cycles into a DMA, then restart it
      ppu_log.delete();
      run_dma(8'h02, 100, cnt, ill);
      chk("abort_at_cycle", 16'(cnt), 16'd100);
      ppu_log.delete();
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!cpu_ce) bad++;
         nxt();
      end
      chk("abort_ce_stays", 16'(bad), 16'd0);
      chk("abort_no_ppu_we", 16'(ppu_log.size()), 16'd0);
      run_dma(8'h02, 0, cnt, ill);
      chk("restart_stall_cycles", 16'(cnt), 16'd513);
      bad = 0;
      foreach (ppu_log[i]) if (ppu_log[i] !== {3'd4, 8'(i)}) bad++;
      chk("restart_dma_data", 16'(bad) + 16'(ppu_log.size() != 256), 16'd0);

      // Randomized traffic against the bench model
      cpu_addr = 16'h0001;
      @(negedge clk);
      chk("rand_seed_read", {8'd0, cpu_din}, {8'd0, model_ram[1]});
      last_exp = model_ram[1];
      nxt();
      for (int n = 0; n < 300; n++) begin
         idle_bus();
         case ($urandom_range(0, 4))
            0: begin
               a = 16'($urandom_range(0, 16'h1FFF)); d = 8'($urandom);
               cpu_wreq = 1'b1; cpu_eawr = a; cpu_dout = d;
               @(negedge clk);
               chk("rnd_ram_we", {15'd0, ram_we}, 16'd1);
               chk("rnd_ram_waddr", {5'd0, ram_addr}, {5'd0, a[10:0]});
               chk("rnd_wr_open_bus", {8'd0, cpu_din}, {8'd0, last_exp});
               model_ram[a[10:0]] = d;
            end
            1: begin
               a = 16'($urandom_range(0, 16'h1FFF)); cpu_addr = a;
               exp = model_ram[a[10:0]];
               @(negedge clk);
               chk("rnd_ram_read", {8'd0, cpu_din}, {8'd0, exp});
               last_exp = exp;
            end
            2: begin
               a = 16'($urandom_range(16'h8000, 16'hFFFF)); cpu_addr = a;
               exp = prgf(a[14:0]);
               @(negedge clk);
               chk("rnd_prg_read", {8'd0, cpu_din}, {8'd0, exp});
               last_exp = exp;
            end
            3: begin
               a = 16'($urandom_range(16'h4020, 16'h7FFF)); cpu_addr = a;
               @(negedge clk);
               chk("rnd_open_bus", {8'd0, cpu_din}, {8'd0, last_exp});
            end
            default: begin
               a = 16'($urandom_range(16'h2000, 16'h3FFF)); cpu_addr = a;
               exp = 8'hC0 | {5'd0, a[2:0]};
               @(negedge clk);
               chk("rnd_ppu_read", {8'd0, cpu_din}, {8'd0, exp});
               chk("rnd_ppu_re_fetch", {15'd0, ppu_re}, 16'd0);
               last_exp = exp;
            end
         endcase
         nxt();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
